// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver with a frame-synchronous shadow buffer.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module seg7_scan_driver #(
    parameter int DIV_MAX   = 99999,
    parameter int DIV_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        load,
    input  logic        blank,
    output logic [7:0]  anode,
    output logic [7:0]  segment,
    output logic        frame_done
);

    // load is a one-cycle strobe with no ready: every cycle it is high is accepted.
    logic [DIV_WIDTH-1:0] cnt;
    logic [2:0]           idx;
    logic [31:0]          shadow;
    logic [7:0]           shadow_dp;
    logic [31:0]          pending;
    logic [7:0]           pend_dp;
    logic                 pend_valid;

    logic       tick;
    logic       wrap;
    logic [3:0] nibble;
    logic       suppress;
    logic [7:0] anode_nx;
    logic [7:0] segment_nx;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick   = (cnt == DIV_WIDTH'(DIV_MAX));
    assign wrap   = tick && (idx == 3'd7);
    assign nibble = shadow[{idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] zero_above;

    // zero_above[k]: nibbles k..7 of the shadow word are all zero.
    always_comb begin
        zero_above = '0;
        for (int k = 0; k < 8; k++) begin
            zero_above[k] = ((shadow >> (4 * k)) == 32'd0);
        end
    end

    assign suppress = (idx != 3'd0) && zero_above[idx] && !shadow_dp[idx];
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        anode_nx   = 8'hFF;
        segment_nx = {~shadow_dp[idx], decode(nibble)};
        if (!blank && !suppress) begin
            anode_nx = ~(8'b1 << idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load coinciding with the wrap bypasses pending and lands in the shadow directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (wrap) begin
            pend_valid <= 1'b0;
            if (load) begin
                shadow    <= data_in;
                shadow_dp <= dp_in;
            end else if (pend_valid) begin
                shadow    <= pending;
                shadow_dp <= pend_dp;
            end
        end else if (load) begin
            pending    <= data_in;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode      <= 8'hFF;
            segment    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            anode      <= anode_nx;
            segment    <= segment_nx;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-clock digit period (32-clock frame).
// Reference state tracks the displayed word and the pending word from the bench side.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        load;
    logic        blank;
    logic [7:0]  anode;
    logic [7:0]  segment;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // n counts clock edges since reset release; outputs after edge n show digit ((n-1)/4)%8.
    int          n;
    logic [31:0] sh_word;
    logic [7:0]  sh_dp;
    logic [31:0] nx_word;
    logic [7:0]  nx_dp;
    bit          nx_valid;
    bit          ld_pend;
    logic [31:0] ld_word;
    logic [7:0]  ld_dp;
    logic [6:0]  tbl [16];
    logic [7:0]  lit_mask;

    seg7_scan_driver #(.DIV_MAX(3), .DIV_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank      (blank),
        .anode      (anode),
        .segment    (segment),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic tick1();
        int d;
        logic [7:0] ea;
        logic [7:0] es;
        @(posedge clk);
        #1;
        n++;
        if (n > 1 && (n % 32) == 1 && nx_valid) begin
            sh_word  = nx_word;
            sh_dp    = nx_dp;
            nx_valid = 1'b0;
        end
        if (ld_pend) begin
            nx_word  = ld_word;
            nx_dp    = ld_dp;
            nx_valid = 1'b1;
        end
        d  = ((n - 1) / 4) % 8;
        ea = blank ? 8'hFF : ~(8'b1 << d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d > 0 && (sh_word >> (4 * d)) == 32'd0 && !sh_dp[d]) ea = 8'hFF;
`endif
        es = {~sh_dp[d], tbl[sh_word[4*d +: 4]]};
        chk("anode", anode, ea);
        chk("segment", segment, es);
        chk("frame_done", {7'd0, frame_done}, {7'd0, (n % 32) == 0});
        lit_mask = lit_mask | ~anode;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick1();
    endtask

    task automatic do_load(input logic [31:0] w, input logic [7:0] dp);
        data_in = w;
        dp_in   = dp;
        load    = 1'b1;
        ld_word = w;
        ld_dp   = dp;
        ld_pend = 1'b1;
        tick1();
        load    = 1'b0;
        ld_pend = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 400 && n < target; i++) tick1();
    endtask

    initial begin
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst = 1'b1; data_in = '0; dp_in = '0; load = 1'b0; blank = 1'b0;
        n = 0; sh_word = '0; sh_dp = '0; nx_word = '0; nx_dp = '0;
        nx_valid = 1'b0; ld_pend = 1'b0; ld_word = '0; ld_dp = '0; lit_mask = '0;

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_anode", anode, 8'hFF);
        chk("rst_segment", segment, 8'hFF);
        chk("rst_frame_done", {7'd0, frame_done}, 8'h00);

        // Release and scan a blank-free all-zero display across a frame.
        rst = 1'b0;
        @(posedge clk);
        #1;
        n = 1;
        chk("first_anode", anode, 8'hFE);
        chk("first_segment", segment, 8'hC0);
        run(39);

        // Mid-frame load: unchanged until the wrap at edge 64, new word from edge 65.
        do_load(32'h0123_89AF, 8'h00);
        run_to(64);
        chk("hold_until_wrap", segment, 8'hC0);
        tick1();
        chk("new_digit0", segment, 8'h8E);
        run_to(96);

        // Pending 1111_1111, then a 2222_2222 load in the wrap cycle (edge 128).
        run_to(100);
        do_load(32'h1111_1111, 8'h00);
        run_to(127);
        do_load(32'h2222_2222, 8'h00);
        tick1();
        chk("sim_load_digit0", segment, 8'hA4);
        run_to(192);
        chk("pend_cleared", segment, 8'hA4);

        // Decimal points on digits 0 and 2 with data 0, visible from edge 225.
        run_to(200);
        do_load(32'h0000_0000, 8'h05);
        run_to(226);
        chk("dp_digit0", segment, 8'h40);
        run_to(232);

        // Blank for 10 cycles; scanning keeps advancing underneath.
        blank = 1'b1;
        tick1();
        chk("blank_anode", anode, 8'hFF);
        run(9);
        blank = 1'b0;
        run_to(256);

        // Pending load, then async reset while digit 5 is displayed.
        run_to(262);
        do_load(32'h3333_3333, 8'h00);
        for (int i = 0; i < 40 && !(((n - 1) / 4) % 8 == 5 && (n - 1) % 4 == 1); i++) tick1();
        chk("at_digit5", anode, 8'hDF);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_anode", anode, 8'hFF);
        chk("mid_rst_segment", segment, 8'hFF);
        chk("mid_rst_frame_done", {7'd0, frame_done}, 8'h00);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_anode", anode, 8'hFF);
        rst = 1'b0;
        n = 0; sh_word = '0; sh_dp = '0; nx_valid = 1'b0;
        tick1();
        chk("post_rst_segment", segment, 8'hC0);
        run(71);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Only digits 0 and 1 may light once 0000_00A5 is shown.
        run_to(80);
        do_load(32'h0000_00A5, 8'h00);
        run_to(96);
        lit_mask = '0;
        run(64);
        chk("lz_lit_mask", lit_mask, 8'h03);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
